// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and slave-to-master response mux with a built-in default slave.
// Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR response and are counted in err_cnt_o.
module ahb_decoder_mux #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NSLV = 2,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h0004_0000, 32'h0000_0000},
  parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hFFFC_0000, 32'hFFFC_0000}
) (
  input  logic                 hclk_i,
  input  logic                 hrst_i,
  input  logic [AW-1:0]        haddr_i,
  input  logic [1:0]           htrans_i,
  output logic [NSLV-1:0]      hsel_o,
  input  logic [NSLV*DW-1:0]   hrdata_s_i,
  input  logic [NSLV-1:0]      hreadyout_s_i,
  input  logic [NSLV-1:0]      hresp_s_i,
  output logic [DW-1:0]        hrdata_o,
  output logic                 hready_o,
  output logic                 hresp_o,
  output logic [15:0]          err_cnt_o,
  output logic [1:0]           dbg_state_o
);

  // Handshake: an address phase is accepted on a rising edge where hready_o is 1;
  // a data phase completes on the edge where hready_o is 1.

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NSLV-1:0] match;
  logic            hit;
  logic [IW-1:0]   win_idx;
  logic            dsel_def;
  logic [IW-1:0]   dsel_idx;
  logic            err_start;
  logic [15:0]     err_cnt;
  logic            unused_trans_lsb;

  // BUSY vs IDLE and SEQ vs NONSEQ make no difference to decoding.
  assign unused_trans_lsb = htrans_i[0];

  always_comb begin
    for (int i = 0; i < NSLV; i++) begin
      match[i] = ((haddr_i & SLV_MASK[i*AW +: AW]) ==
                  (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]));
    end
  end

  // Lowest matching index wins, so hsel_o is at most one-hot.
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    hsel_o  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (!hit && match[i]) begin
        hit       = 1'b1;
        win_idx   = IW'(i);
        hsel_o[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      dsel_def <= 1'b1;
      dsel_idx <= '0;
    end else if (hready_o) begin
      dsel_def <= !hit;
      dsel_idx <= win_idx;
    end
  end

  always_comb begin
    hrdata_o = '0;
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    if (dsel_def) begin
      case (state)
        S_ERR1: begin
          hready_o = 1'b0;
          hresp_o  = 1'b1;
        end
        S_ERR2: begin
          hready_o = 1'b1;
          hresp_o  = 1'b1;
        end
        default: ;
      endcase
    end else begin
      for (int i = 0; i < NSLV; i++) begin
        if (dsel_idx == IW'(i)) begin
          hrdata_o = hrdata_s_i[i*DW +: DW];
          hready_o = hreadyout_s_i[i];
          hresp_o  = hresp_s_i[i];
        end
      end
    end
  end

  assign err_start = hready_o && !hit && htrans_i[1];

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (err_start) state_nxt = S_ERR1;
      S_ERR1:  state_nxt = S_ERR2;
      S_ERR2:  state_nxt = err_start ? S_ERR1 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // err_start can only fire from IDLE or ERR2 since ERR1 holds hready_o low.
  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i)                                  err_cnt <= 16'h0000;
    else if (err_start && err_cnt != 16'hFFFF)   err_cnt <= err_cnt + 16'd1;
  end

  assign err_cnt_o   = err_cnt;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Randomized scoreboard bench for ahb_decoder_mux: the driver pushes one expected response
// per accepted address phase, and a negedge monitor pops each one as its data phase completes.
module tb_ahb_decoder_mux;

  typedef struct packed {
    logic [2:0]  waits;
    logic [31:0] data;
    logic        resp;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  logic        hclk_i = 1'b0;
  logic        hrst_i;
  logic [31:0] haddr_i;
  logic [1:0]  htrans_i;
  logic [1:0]  hsel_o;
  logic [63:0] hrdata_s_i;
  logic [1:0]  hreadyout_s_i;
  logic [1:0]  hresp_s_i;
  logic [31:0] hrdata_o;
  logic        hready_o;
  logic        hresp_o;
  logic [15:0] err_cnt_o;
  logic [1:0]  dbg_state_o;

  logic [1:0]  ov_hsel;
  logic [31:0] ov_hrdata;
  logic        ov_hready;
  logic        ov_hresp;
  logic [15:0] ov_err_cnt;
  logic [1:0]  ov_dbg_state;

  exp_t        exp_q[$];
  exp_t        cur;
  int          cur_idx;
  logic [15:0] m_cnt;
  logic        mon_en = 1'b0;
  int          mon_cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 hclk_i = ~hclk_i;

  ahb_decoder_mux dut (
    .hclk_i(hclk_i), .hrst_i(hrst_i), .haddr_i(haddr_i), .htrans_i(htrans_i),
    .hsel_o(hsel_o), .hrdata_s_i(hrdata_s_i), .hreadyout_s_i(hreadyout_s_i),
    .hresp_s_i(hresp_s_i), .hrdata_o(hrdata_o), .hready_o(hready_o),
    .hresp_o(hresp_o), .err_cnt_o(err_cnt_o), .dbg_state_o(dbg_state_o)
  );

  ahb_decoder_mux #(
    .SLV_BASE({32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFC_0000, 32'hFFFC_0000})
  ) dut_ov (
    .hclk_i(hclk_i), .hrst_i(hrst_i), .haddr_i(haddr_i), .htrans_i(htrans_i),
    .hsel_o(ov_hsel), .hrdata_s_i(hrdata_s_i), .hreadyout_s_i(hreadyout_s_i),
    .hresp_s_i(hresp_s_i), .hrdata_o(ov_hrdata), .hready_o(ov_hready),
    .hresp_o(ov_hresp), .err_cnt_o(ov_err_cnt), .dbg_state_o(ov_dbg_state)
  );

  // Reference memory map: slave 0 owns [0x0, 0x3FFFF], slave 1 owns [0x40000, 0x7FFFF].
  function automatic int ref_decode(input logic [31:0] a);
    if (a <= 32'h0003_FFFF) return 0;
    if (a <= 32'h0007_FFFF) return 1;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic slave_noise();
    hrdata_s_i    = {$urandom, $urandom};
    hreadyout_s_i = 2'($urandom_range(0, 3));
    hresp_s_i     = 2'($urandom_range(0, 3));
  endtask

  // Runs the data phase currently in flight, presenting the new address phase on its last cycle.
  task automatic do_xfer(input logic [31:0] addr, input logic [1:0] trans, input int w,
                         input logic [31:0] d);
    int   idx;
    exp_t e;
    idx   = ref_decode(addr);
    e.err = (idx < 0) && trans[1];
    if (idx < 0) begin
      e.data  = 32'h0;
      e.resp  = e.err;
      e.waits = e.err ? 3'd1 : 3'd0;
      if (e.err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      e.data  = d;
      e.resp  = trans[1] ? ($urandom_range(0, 7) == 0) : 1'b0;
      e.waits = trans[1] ? 3'((w < 0) ? $urandom_range(0, 3) : w) : 3'd0;
    end
    e.cnt = m_cnt;
    for (int c = 0; c <= int'(cur.waits); c++) begin
      slave_noise();
      if (cur_idx >= 0) begin
        hreadyout_s_i[cur_idx]       = (c == int'(cur.waits));
        hresp_s_i[cur_idx]           = (c == int'(cur.waits)) ? cur.resp : 1'b0;
        hrdata_s_i[cur_idx*32 +: 32] = (c == int'(cur.waits)) ? cur.data : $urandom;
      end
      if (c == int'(cur.waits)) begin
        haddr_i  = addr;
        htrans_i = trans;
      end else begin
        haddr_i  = $urandom;
        htrans_i = 2'($urandom_range(0, 3));
      end
      @(posedge hclk_i);
      #1;
    end
    cur     = e;
    cur_idx = idx;
    exp_q.push_back(e);
  endtask

  function automatic exp_t reset_entry(input logic [15:0] cnt);
    exp_t e;
    e.waits = 3'd0;
    e.data  = 32'h0;
    e.resp  = 1'b0;
    e.err   = 1'b0;
    e.cnt   = cnt;
    return e;
  endfunction

  always @(negedge hclk_i) begin
    if (!mon_en) begin
      mon_cyc = 0;
    end else begin
      int   idx;
      exp_t e;
      idx = ref_decode(haddr_i);
      check("hsel", 64'(hsel_o), (idx < 0) ? 64'd0 : (64'd1 << idx));
      if (exp_q.size() == 0) begin
        check("queue_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q[0];
        if (mon_cyc < int'(e.waits)) begin
          check("wait_hready", 64'(hready_o), 64'd0);
          check("wait_hresp", 64'(hresp_o), 64'(e.err));
          mon_cyc++;
        end else begin
          check("hready", 64'(hready_o), 64'd1);
          check("hrdata", 64'(hrdata_o), 64'(e.data));
          check("hresp", 64'(hresp_o), 64'(e.resp));
          check("err_cnt", 64'(err_cnt_o), 64'(e.cnt));
          void'(exp_q.pop_front());
          mon_cyc = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    hrst_i   = 1'b1;
    haddr_i  = 32'h0010_0000;
    htrans_i = 2'b10;
    slave_noise();
    repeat (3) @(negedge hclk_i);
    check("rst_hready", 64'(hready_o), 64'd1);
    check("rst_hresp", 64'(hresp_o), 64'd0);
    check("rst_hrdata", 64'(hrdata_o), 64'd0);
    check("rst_err_cnt", 64'(err_cnt_o), 64'd0);

    // Overlapping regions: the lower index must win alone.
    haddr_i = 32'h0000_1000; #1;
    check("ov_hsel_low", 64'(ov_hsel), 64'd1);
    haddr_i = 32'h0003_FFFC; #1;
    check("ov_hsel_top", 64'(ov_hsel), 64'd1);
    haddr_i = 32'h0004_0000; #1;
    check("ov_hsel_none", 64'(ov_hsel), 64'd0);

    @(posedge hclk_i); #1;
    hrst_i  = 1'b0;
    m_cnt   = 16'h0;
    cur     = reset_entry(16'h0);
    cur_idx = -1;
    exp_q.push_back(cur);
    mon_en  = 1'b1;

    do_xfer(32'h0000_1000, 2'b10, 0, 32'hA5A5_A5A5);
    do_xfer(32'h0004_0010, 2'b10, 3, $urandom);
    do_xfer(32'h0010_0000, 2'b10, 0, 32'h0);
    do_xfer(32'h0010_0000, 2'b10, 0, 32'h0);
    do_xfer(32'h0020_0000, 2'b11, 0, 32'h0);
    do_xfer(32'h0030_0000, 2'b00, 0, 32'h0);
    do_xfer(32'h0030_0004, 2'b01, 0, 32'h0);
    do_xfer(32'h0000_2000, 2'b11, 2, $urandom);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'($urandom_range(0, 32'h0003_FFFF));
        1:       a = 32'h0004_0000 + 32'($urandom_range(0, 32'h0003_FFFF));
        default: a = 32'h0008_0000 | $urandom;
      endcase
      do_xfer(a, 2'($urandom_range(0, 3)), -1, $urandom);
    end
    do_xfer(32'h00F0_0000, 2'b00, 0, 32'h0);
    @(negedge hclk_i); #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while the default slave sits in ERR1.
    mon_en   = 1'b0;
    exp_q.delete();
    haddr_i  = 32'h0010_0000;
    htrans_i = 2'b10;
    @(negedge hclk_i);
    check("err1_hready", 64'(hready_o), 64'd0);
    check("err1_hresp", 64'(hresp_o), 64'd1);
    check("err1_cnt", 64'(err_cnt_o), (m_cnt == 16'hFFFF) ? 64'hFFFF : 64'(m_cnt + 16'd1));
    #2 hrst_i = 1'b1;
    #1;
    check("async_rst_hready", 64'(hready_o), 64'd1);
    check("async_rst_hresp", 64'(hresp_o), 64'd0);
    check("async_rst_hrdata", 64'(hrdata_o), 64'd0);
    check("async_rst_err_cnt", 64'(err_cnt_o), 64'd0);
    htrans_i = 2'b00;
    @(posedge hclk_i); #1;
    hrst_i = 1'b0;

    // Counter saturation from a preloaded 0xFFFE.
    force dut.err_cnt = 16'hFFFE;
    m_cnt   = 16'hFFFE;
    cur     = reset_entry(16'hFFFE);
    cur_idx = -1;
    exp_q.push_back(cur);
    mon_en  = 1'b1;
    do_xfer(32'h00F0_0000, 2'b00, 0, 32'h0);
    release dut.err_cnt;
    do_xfer(32'h0010_0000, 2'b10, 0, 32'h0);
    do_xfer(32'h0010_0000, 2'b11, 0, 32'h0);
    do_xfer(32'h0010_0000, 2'b10, 0, 32'h0);
    do_xfer(32'h00F0_0000, 2'b00, 0, 32'h0);
    @(negedge hclk_i); #1;
    check("sat_queue_drained", 64'(exp_q.size()), 64'd0);
    check("sat_err_cnt", 64'(err_cnt_o), 64'hFFFF);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
